// File: rtl/lif_pkg.sv
// Shared definitions for the LIF neuron array: reset-mode codes and saturating add.
// Latency: n/a (constants and a combinational helper only).
// Backpressure: n/a.
package lif_pkg;

    // Reset behaviour applied to a neuron's membrane state when it fires.
    localparam logic RESET_ZERO = 1'b0;  // state returns to 0
    localparam logic RESET_SUB  = 1'b1;  // state keeps the overshoot (v - threshold)

    // Unsigned add of two values of at most 32 bits, clamped to 2^width-1.
    // The 33-bit intermediate keeps the carry so the clamp never misses a wrap.
    // Callers cast the result back down to their own width.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input int unsigned width);
        logic [32:0] sum;
        logic [32:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = (33'd1 << width) - 33'd1;
        return (sum > lim) ? lim[31:0] : sum[31:0];
    endfunction

endpackage

// File: rtl/lif_neuron_array_if.sv
// Control/data bundle between a driver and the LIF neuron array.
// Latency: n/a (wires only).
// Backpressure: none; the array accepts new currents on every enabled edge.
//   master: drives en, current, threshold, reset_mode, sel; observes spike, state_out, spike_count
//   slave : the array, the mirror image of master
interface lif_neuron_array_if #(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int CW = 16,
    parameter int SW = (N > 1) ? $clog2(N) : 1
);
    logic            en;
    logic [N*W-1:0]  current;
    logic [W-1:0]    threshold;
    logic            reset_mode;
    logic [SW-1:0]   sel;
    logic [N-1:0]    spike;
    logic [W-1:0]    state_out;
    logic [CW-1:0]   spike_count;

    modport master (
        output en, current, threshold, reset_mode, sel,
        input  spike, state_out, spike_count
    );

    modport slave (
        input  en, current, threshold, reset_mode, sel,
        output spike, state_out, spike_count
    );
endinterface

// File: rtl/lif_cell.sv
// One leaky integrate-and-fire neuron with a refractory counter.
// Latency: current sampled at edge k updates state/spike at edge k; fire_next is combinational.
// Backpressure: none; en=0 freezes state and refractory count and forces spike low.
//   inputs : clk, rst_n, en, current[W], threshold[W], reset_mode
//   outputs: fire_next (this edge's spike decision), spike (registered), state[W]
module lif_cell
    import lif_pkg::*;
#(
    parameter int W          = 8,
    parameter int LEAK_SHIFT = 2,
    parameter int REFRACT    = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] current,
    input  logic [W-1:0] threshold,
    input  logic         reset_mode,
    output logic         fire_next,
    output logic         spike,
    output logic [W-1:0] state
);

    localparam int RW = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;

    logic [RW-1:0] rcnt;
    logic [W-1:0]  leaked;
    logic [W-1:0]  v;
    logic          integrate;

    // state >> LEAK_SHIFT never exceeds state, so this cannot underflow.
    assign leaked    = state - (state >> LEAK_SHIFT);
    assign v         = W'(sat_add(32'(leaked), 32'(current), W));
    assign integrate = (rcnt == '0);
    // A zero threshold disables firing entirely rather than firing every edge.
    assign fire_next = en && integrate && (threshold != '0) && (v >= threshold);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= '0;
            rcnt  <= '0;
            spike <= 1'b0;
        end else begin
            spike <= fire_next;
            if (en) begin
                if (!integrate) begin
                    // Refractory: input and leak are both ignored, state is held.
                    rcnt <= rcnt - RW'(1);
                end else if (fire_next) begin
                    rcnt  <= RW'(REFRACT);
                    state <= (reset_mode == RESET_SUB) ? (v - threshold) : '0;
                end else begin
                    state <= v;
                end
            end
        end
    end

endmodule

// File: rtl/lif_neuron_array.sv
// Array of N LIF neurons sharing threshold/reset mode, with a saturating spike counter and state read-back.
// Latency: spike and spike_count update on the edge that samples current; state_out lags state by one edge.
// Backpressure: none; en=0 holds every neuron and the counter, spikes read as 0.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : lif_neuron_array_if.slave (en, current, threshold, reset_mode, sel -> spike, state_out, spike_count)
module lif_neuron_array
    import lif_pkg::*;
#(
    parameter int N          = 4,
    parameter int W          = 8,
    parameter int LEAK_SHIFT = 2,
    parameter int REFRACT    = 3,
    parameter int CW         = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    lif_neuron_array_if.slave bus
);

    logic [N-1:0]  fire_next;
    logic [N-1:0]  spike_q;
    logic [W-1:0]  state_arr [N];
    logic [31:0]   pop;
    logic [W-1:0]  rd_state;
    logic [W-1:0]  state_out_q;
    logic [CW-1:0] count_q;

    for (genvar i = 0; i < N; i++) begin : g_cell
        lif_cell #(
            .W          (W),
            .LEAK_SHIFT (LEAK_SHIFT),
            .REFRACT    (REFRACT)
        ) u_cell (
            .clk        (clk),
            .rst_n      (rst_n),
            .en         (bus.en),
            .current    (bus.current[i*W +: W]),
            .threshold  (bus.threshold),
            .reset_mode (bus.reset_mode),
            .fire_next  (fire_next[i]),
            .spike      (spike_q[i]),
            .state      (state_arr[i])
        );
    end

    // Count this edge's spikes so spike_count moves in step with spike.
    always_comb begin
        pop = '0;
        for (int i = 0; i < N; i++) begin
            pop = pop + 32'(fire_next[i]);
        end
    end

    // Select by comparison rather than indexing so a sel beyond N-1 reads 0.
    always_comb begin
        rd_state = '0;
        for (int i = 0; i < N; i++) begin
            if (32'(bus.sel) == 32'(i)) begin
                rd_state = state_arr[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_out_q <= '0;
            count_q     <= '0;
        end else begin
            state_out_q <= rd_state;
            if (bus.en) begin
                count_q <= CW'(sat_add(32'(count_q), pop, CW));
            end
        end
    end

    assign bus.spike       = spike_q;
    assign bus.state_out   = state_out_q;
    assign bus.spike_count = count_q;

endmodule

// File: tb/tb_lif_neuron_array.sv
// Directed bench for lif_neuron_array: a 4-neuron instance for the main behaviour and a
// 3-neuron, 3-bit-counter instance for out-of-range read-back and counter saturation.
// Expected values are hand-computed for LEAK_SHIFT=2, REFRACT=3.
module tb_lif_neuron_array;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lif_neuron_array_if #(.N(4), .W(8), .CW(16)) ifc ();
    lif_neuron_array_if #(.N(3), .W(8), .CW(3))  ifc2 ();

    lif_neuron_array #(.N(4), .W(8), .LEAK_SHIFT(2), .REFRACT(3), .CW(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    lif_neuron_array #(.N(3), .W(8), .LEAK_SHIFT(2), .REFRACT(3), .CW(3)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc2)
    );

    int          n_err = 0;
    int          n_chk = 0;
    string       phase = "init";
    logic [7:0]  prev_exp = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s/%s observed=%0d expected=%0d", phase, tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One enabled edge on the main instance: spike and count belong to this edge,
    // state_out shows the state predicted for the previous edge.
    task automatic step(input logic [3:0] es, input logic [7:0] est, input logic [15:0] ec);
        tick();
        chk("spike", 32'(ifc.spike), 32'(es));
        chk("count", 32'(ifc.spike_count), 32'(ec));
        chk("state_out", 32'(ifc.state_out), 32'(prev_exp));
        prev_exp = est;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        prev_exp = '0;
    endtask

    initial begin
        ifc2.en = 1'b0; ifc2.current = '0; ifc2.threshold = '0;
        ifc2.reset_mode = 1'b0; ifc2.sel = '0;

        // Reset held with random inputs.
        phase = "reset";
        ifc.en = 1'b1;
        ifc.current = $urandom;
        ifc.threshold = 8'($urandom_range(1, 255));
        ifc.reset_mode = 1'($urandom_range(0, 1));
        ifc.sel = 2'($urandom_range(0, 3));
        repeat (3) tick();
        chk("spike", 32'(ifc.spike), 0);
        chk("state_out", 32'(ifc.state_out), 0);
        chk("count", 32'(ifc.spike_count), 0);

        // Neuron 0 integrates 30/edge against threshold 100, reset-to-zero.
        phase = "integrate";
        ifc.en = 1'b1; ifc.current = {8'd0, 8'd0, 8'd0, 8'd30};
        ifc.threshold = 8'd100; ifc.reset_mode = 1'b0; ifc.sel = 2'd0;
        #2 rst_n = 1'b1;
        prev_exp = '0;
        step(4'b0000, 8'd30, 16'd0);
        step(4'b0000, 8'd53, 16'd0);
        step(4'b0000, 8'd70, 16'd0);
        step(4'b0000, 8'd83, 16'd0);
        step(4'b0000, 8'd93, 16'd0);
        step(4'b0001, 8'd0,  16'd1);
        step(4'b0000, 8'd0,  16'd1);
        step(4'b0000, 8'd0,  16'd1);
        step(4'b0000, 8'd0,  16'd1);
        step(4'b0000, 8'd30, 16'd1);
        step(4'b0000, 8'd53, 16'd1);

        // Asynchronous reset between edges clears outputs immediately.
        phase = "async_reset";
        #2 rst_n = 1'b0;
        #1;
        chk("state_out", 32'(ifc.state_out), 0);
        chk("count", 32'(ifc.spike_count), 0);

        // Subtract mode: 120 from 0 fires and leaves 20; refractory holds 20; 20-5+120=135 leaves 35.
        phase = "subtract";
        ifc.current = {8'd0, 8'd0, 8'd0, 8'd120};
        ifc.threshold = 8'd100; ifc.reset_mode = 1'b1; ifc.sel = 2'd0;
        #1 rst_n = 1'b1;
        prev_exp = '0;
        step(4'b0001, 8'd20, 16'd1);
        step(4'b0000, 8'd20, 16'd1);
        step(4'b0000, 8'd20, 16'd1);
        step(4'b0000, 8'd20, 16'd1);
        step(4'b0001, 8'd35, 16'd2);
        step(4'b0000, 8'd35, 16'd2);

        // All four fire together; en=0 mid-refractory freezes everything.
        phase = "simultaneous";
        do_reset();
        ifc.current = {4{8'd120}}; ifc.sel = 2'd2;
        step(4'b1111, 8'd20, 16'd4);
        ifc.en = 1'b0;
        step(4'b0000, 8'd20, 16'd4);
        step(4'b0000, 8'd20, 16'd4);
        ifc.en = 1'b1;
        step(4'b0000, 8'd20, 16'd4);
        step(4'b0000, 8'd20, 16'd4);
        step(4'b0000, 8'd20, 16'd4);
        step(4'b1111, 8'd35, 16'd8);

        // Saturation with firing disabled, then a lowered threshold fires at once.
        phase = "saturate";
        do_reset();
        ifc.threshold = 8'd0; ifc.reset_mode = 1'b0; ifc.sel = 2'd1;
        ifc.current = {8'd0, 8'd0, 8'd200, 8'd0};
        step(4'b0000, 8'd200, 16'd0);
        ifc.current = {8'd0, 8'd0, 8'd255, 8'd0};
        step(4'b0000, 8'd255, 16'd0);
        step(4'b0000, 8'd255, 16'd0);
        ifc.threshold = 8'd150; ifc.current = '0;
        step(4'b0010, 8'd0, 16'd1);
        step(4'b0000, 8'd0, 16'd1);

        // Read-back sweep over distinct frozen states.
        phase = "readback";
        do_reset();
        ifc.threshold = 8'd0; ifc.current = {8'd40, 8'd30, 8'd20, 8'd10}; ifc.sel = 2'd0;
        step(4'b0000, 8'd10, 16'd0);
        ifc.en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ifc.sel = 2'(i);
            tick();
            chk("sweep", 32'(ifc.state_out), 32'(10 * (i + 1)));
        end

        // Three-neuron instance: sel beyond N reads 0; 3-bit counter saturates at 7.
        phase = "n3";
        do_reset();
        ifc2.en = 1'b1; ifc2.current = {3{8'd255}}; ifc2.threshold = 8'd200;
        ifc2.reset_mode = 1'b1; ifc2.sel = 2'd3;
        tick();
        chk("spike", 32'(ifc2.spike), 32'd7);
        chk("count", 32'(ifc2.spike_count), 32'd3);
        tick();
        chk("sel_oob", 32'(ifc2.state_out), 32'd0);
        repeat (2) tick();
        tick();
        chk("count", 32'(ifc2.spike_count), 32'd6);
        repeat (3) tick();
        tick();
        chk("count_sat", 32'(ifc2.spike_count), 32'd7);
        ifc2.sel = 2'd2;
        tick();
        chk("sel2", 32'(ifc2.state_out), 32'd55);
        repeat (2) tick();
        tick();
        chk("spike", 32'(ifc2.spike), 32'd7);
        chk("count_hold", 32'(ifc2.spike_count), 32'd7);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
